grid_io_bank_right_out: RTL and testbench



---
 rtl/grid_io_bank_right_out_pkg.sv | 32 +++
 rtl/grid_io_bank_right_out_if.sv | 30 +++
 rtl/grid_io_bank_right_out_ccff_chain.sv | 56 +++++
 rtl/grid_io_bank_right_out.sv | 129 ++++++++++++
 tb/tb_grid_io_bank_right_out.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/grid_io_bank_right_out_pkg.sv
`default_nettype none
// ============================================================================
// Package : grid_io_bank_pkg
// Brief   : Shared types, constants and helpers for the right-edge output IO
//           bank. Macro CCFF_PARITY_EN adds one parity bit to the frame.
// Rev     : 1.0  initial release
// ============================================================================
package grid_io_bank_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam int CFG_BITS = 2;
  localparam int EN_BIT   = 0;
  localparam int INV_BIT  = 1;

`ifdef CCFF_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Frame length in bits: per-channel config plus optional parity bit.
  function automatic int cfg_len(input int num_pads, input bit parity);
    return num_pads * CFG_BITS + (parity ? 1 : 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/grid_io_bank_right_out_if.sv
`default_nettype none
// ============================================================================
// Interface : grid_io_bank_right_out_if
// Brief     : Config chain and pad signals of the right-edge output IO bank.
//             master = fabric/config side, slave = the IO bank.
// Rev       : 1.0  initial release
// ============================================================================
interface grid_io_bank_right_out_if #(
  parameter int NUM_PADS = 4
);
  logic                config_enable;
  logic                ccff_head;
  logic                ccff_tail;
  logic [NUM_PADS-1:0] pin_outpad;
  logic [NUM_PADS-1:0] gfpga_pad_GPIO_PAD;
  logic [NUM_PADS-1:0] pin_inpad;
  logic                cfg_done;
  logic                cfg_err;

  modport master (
    output config_enable, ccff_head, pin_outpad,
    input  ccff_tail, gfpga_pad_GPIO_PAD, pin_inpad, cfg_done, cfg_err
  );

  modport slave (
    input  config_enable, ccff_head, pin_outpad,
    output ccff_tail, gfpga_pad_GPIO_PAD, pin_inpad, cfg_done, cfg_err
  );
endinterface
`default_nettype wire

// File: rtl/grid_io_bank_right_out_ccff_chain.sv
`default_nettype none
// ============================================================================
// Module : grid_io_bank_ccff_chain
// Brief  : Serial config shift register with a saturating shift counter.
//          The counter saturates one past the frame length to flag overflow.
// Rev    : 1.0  initial release
// ============================================================================
module grid_io_bank_ccff_chain #(
  parameter int L  = 8,
  parameter int CW = 4
) (
  input  logic          prog_clk,
  input  logic          pReset_n,
  input  logic          shift_i,
  input  logic          start_i,
  input  logic          head_i,
  output logic [L-1:0]  chain_o,
  output logic [CW-1:0] cnt_o,
  output logic          tail_o
);

  localparam logic [CW-1:0] C_SAT = CW'(L + 1);

  logic [L-1:0]  chain_q, chain_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next chain/count: shift in head; first shift of a frame restarts the count.
  always_comb begin
    chain_d = chain_q;
    cnt_d   = cnt_q;
    if (shift_i) begin
      chain_d = {chain_q[L-2:0], head_i};
      if (start_i)
        cnt_d = CW'(1);
      else if (cnt_q != C_SAT)
        cnt_d = cnt_q + 1'b1;
    end
  end

  // Chain and counter registers.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      chain_q <= '0;
      cnt_q   <= '0;
    end else begin
      chain_q <= chain_d;
      cnt_q   <= cnt_d;
    end
  end

  assign chain_o = chain_q;
  assign cnt_o   = cnt_q;
  assign tail_o  = chain_q[L-1];

endmodule
`default_nettype wire

// File: rtl/grid_io_bank_right_out.sv
`default_nettype none
// ============================================================================
// Module : grid_io_bank_right_out
// Brief  : Output-only IO bank for the right fabric edge. Per-pad enable and
//          invert bits arrive over the ccff chain in framed loads and commit
//          atomically to a shadow register driving the pads.
//          Macro CCFF_PARITY_EN: frame carries an even-parity bit, shifted first.
// Rev    : 1.0  initial release
// ============================================================================
module grid_io_bank_right_out
  import grid_io_bank_pkg::state_e;
  import grid_io_bank_pkg::IDLE;
  import grid_io_bank_pkg::SHIFT;
  import grid_io_bank_pkg::COMMIT;
  import grid_io_bank_pkg::EN_BIT;
  import grid_io_bank_pkg::INV_BIT;
  import grid_io_bank_pkg::PARITY_EN;
  import grid_io_bank_pkg::cfg_len;
#(
  parameter int NUM_PADS = 4,
  parameter int CFG_BITS = 2
) (
  input  logic                     prog_clk,
  input  logic                     pReset_n,
  grid_io_bank_right_out_if.slave  bus
);

  localparam int SW = NUM_PADS * CFG_BITS;
  localparam int L  = cfg_len(NUM_PADS, PARITY_EN);
  localparam int CW = $clog2(L + 2);
  localparam logic [CW-1:0] C_LEN = CW'(L);

  state_e              state_q, state_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [SW-1:0]       shadow_q, shadow_d;
  logic                shift_w, start_w, par_ok_w;
  logic [L-1:0]        chain_w;
  logic [CW-1:0]       cnt_w;
  logic [NUM_PADS-1:0] pads_w;

  grid_io_bank_ccff_chain #(.L(L), .CW(CW)) u_chain (
    .prog_clk (prog_clk),
    .pReset_n (pReset_n),
    .shift_i  (shift_w),
    .start_i  (start_w),
    .head_i   (bus.ccff_head),
    .chain_o  (chain_w),
    .cnt_o    (cnt_w),
    .tail_o   (bus.ccff_tail)
  );

`ifdef CCFF_PARITY_EN
  assign par_ok_w = ~(^chain_w);
`else
  assign par_ok_w = 1'b1;
`endif

  // Frame FSM: next state, shift control, shadow load and sticky status.
  always_comb begin
    state_d  = state_q;
    done_d   = done_q;
    err_d    = err_q;
    shadow_d = shadow_q;
    shift_w  = 1'b0;
    start_w  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.config_enable) begin
          shift_w = 1'b1;
          start_w = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.config_enable) begin
          shift_w = 1'b1;
        end else if (cnt_w == C_LEN) begin
          state_d = COMMIT;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      COMMIT: begin
        // Parity bit (if any) sits above the payload and is not stored.
        if (par_ok_w) begin
          shadow_d = chain_w[SW-1:0];
          done_d   = 1'b1;
        end else begin
          err_d    = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, shadow and status registers.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
    end
  end

  // Pad drive is combinational from the committed shadow only.
  for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
    assign pads_w[i] = shadow_q[CFG_BITS*i + EN_BIT]
                     ? (bus.pin_outpad[i] ^ shadow_q[CFG_BITS*i + INV_BIT])
                     : 1'b0;
  end

  assign bus.gfpga_pad_GPIO_PAD = pads_w;
  assign bus.pin_inpad          = '0;
  assign bus.cfg_done           = done_q;
  assign bus.cfg_err            = err_q;

endmodule
`default_nettype wire

// File: tb/tb_grid_io_bank_right_out.sv
`default_nettype none
// ============================================================================
// Module : tb_grid_io_bank_right_out
// Brief  : Self-checking bench for grid_io_bank_right_out (NUM_PADS=4).
//          Expected frame outcomes are queued when a frame is driven and
//          popped when the bank reports cfg_done or cfg_err.
// Rev    : 1.0  initial release
// ============================================================================
module tb_grid_io_bank_right_out;
  import grid_io_bank_pkg::*;

  localparam int NP = 4;
  localparam int L  = cfg_len(NP, PARITY_EN);

  typedef struct {
    logic       done;
    logic       err;
    logic [7:0] shadow;
  } exp_t;

  logic prog_clk = 1'b0;
  logic pReset_n;
  always #5 prog_clk = ~prog_clk;

  grid_io_bank_right_out_if #(.NUM_PADS(NP)) bus ();

  grid_io_bank_right_out #(.NUM_PADS(NP), .CFG_BITS(2)) dut (
    .prog_clk (prog_clk),
    .pReset_n (pReset_n),
    .bus      (bus.slave)
  );

  exp_t       sb_q[$];
  logic [7:0] m_shadow;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [NP-1:0] pads_model(input logic [7:0] sh, input logic [NP-1:0] pin);
    logic [NP-1:0] r;
    r = '0;
    for (int i = 0; i < NP; i++)
      r[i] = sh[2*i] ? (pin[i] ^ sh[2*i+1]) : 1'b0;
    return r;
  endfunction

  // Full-length frame with a correct parity bit above the payload when enabled.
  function automatic logic [15:0] mk(input logic [7:0] p);
    logic [15:0] f;
    f = {8'b0, p};
    if (L > 8) f[8] = ^p;
    return f;
  endfunction

  // Shift n bits (bits[n-1] first), end the frame and score the outcome.
  task automatic send_frame(input string tag, input logic [15:0] bits, input int n);
    exp_t e;
    logic par;
    bit   ok;
    bit   got;
    par = 1'b0;
    for (int k = 0; k < L; k++) par ^= bits[k];
    ok = (n == L) && !(L > 8 && par);
    if (ok) m_shadow = bits[7:0];
    e.done = ok; e.err = !ok; e.shadow = m_shadow;
    sb_q.push_back(e);

    for (int k = 0; k < n; k++) begin
      bus.config_enable = 1'b1;
      bus.ccff_head     = bits[n-1-k];
      @(posedge prog_clk); #1;
      if (n > L && k == L - 1)
        check({tag, "_tail_delay"}, bus.ccff_tail, bits[n-1]);
    end
    bus.config_enable = 1'b0;
    bus.ccff_head     = 1'b0;

    got = 0;
    for (int w = 0; w < 6; w++) begin
      @(negedge prog_clk);
      if (bus.cfg_done || bus.cfg_err) begin
        got = 1;
        break;
      end
    end
    e = sb_q.pop_front();
    if (!got) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      check({tag, "_done"}, bus.cfg_done, e.done);
      check({tag, "_err"},  bus.cfg_err,  e.err);
      check({tag, "_pads"}, bus.gfpga_pad_GPIO_PAD, pads_model(e.shadow, bus.pin_outpad));
    end
  endtask

  initial begin
    m_shadow          = '0;
    pReset_n          = 1'b0;
    bus.config_enable = 1'b0;
    bus.ccff_head     = 1'b0;
    bus.pin_outpad    = 4'hF;
    repeat (2) @(negedge prog_clk);
    check("rst_pads", bus.gfpga_pad_GPIO_PAD, 4'h0);
    check("rst_done", bus.cfg_done, 1'b0);
    check("rst_err",  bus.cfg_err,  1'b0);
    check("rst_tail", bus.ccff_tail, 1'b0);
    check("rst_inpad", bus.pin_inpad, 4'h0);
    pReset_n = 1'b1;
    @(negedge prog_clk);

    // Mixed enable/invert frame.
    bus.pin_outpad = 4'b1010;
    send_frame("frame1", mk(8'b01_00_11_01), L);
    bus.pin_outpad = 4'b0101; #1;
    check("frame1_pads_pin2", bus.gfpga_pad_GPIO_PAD, pads_model(m_shadow, 4'b0101));
    bus.pin_outpad = 4'b1010;

    // Short and long frames are rejected; pads keep the committed config.
    send_frame("short", 16'h0055, L - 1);
    send_frame("long",  16'h0166 | (16'h1 << L), L + 1);

`ifdef CCFF_PARITY_EN
    send_frame("bad_par", mk(8'b1111_0101) ^ 16'h0100, L);
    send_frame("good_par", mk(8'b0101_0101), L);
`endif

    // Asynchronous reset in the middle of a frame.
    for (int k = 0; k < 5; k++) begin
      bus.config_enable = 1'b1;
      bus.ccff_head     = k[0];
      @(posedge prog_clk); #1;
    end
    pReset_n = 1'b0;
    #1;
    m_shadow = '0;
    check("midrst_pads", bus.gfpga_pad_GPIO_PAD, 4'h0);
    check("midrst_done", bus.cfg_done, 1'b0);
    check("midrst_err",  bus.cfg_err,  1'b0);
    check("midrst_tail", bus.ccff_tail, 1'b0);
    bus.config_enable = 1'b0;
    bus.ccff_head     = 1'b0;
    @(negedge prog_clk);
    pReset_n = 1'b1;
    @(negedge prog_clk);

    send_frame("after_rst", mk(8'b11_11_11_11), L);

    check("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
